// File: rtl/fifo_rd_pkg.sv
// Shared types for the FWFT FIFO burst reader.
package fifo_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    localparam int BURST_CNT_W = 32;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer with a registered s_ready, so the FIFO pop path
// never depends combinationally on downstream m_ready.
module rd_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              push;
    logic              pop;

    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_valid = (cnt != 2'd0);
    assign m_data  = mem[rd_ptr];
    assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt     <= cnt_nxt;
            // Ready for the next cycle is decided from the post-update fill level.
            s_ready <= (cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains an FWFT FIFO in fixed-length bursts onto a valid/ready stream.
// Optional partial-burst flush on idle timeout: define FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 5,
    parameter int BURST_LEN   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_ren,
    input  logic [DATA_W-1:0]      fifo_rdata,
    input  logic                   fifo_empty,
    input  logic [CNT_W-1:0]       fifo_rdcnt,
    input  logic                   fifo_err,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic                   m_last,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   err_flag
);

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(BURST_LEN);

    if (BURST_LEN < 2 || BURST_LEN > 2**CNT_W - 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("fifo_burst_reader: illegal BURST_LEN/CNT_W/TIMEOUT_CYC");
    end

    rd_state_e        state, state_nxt;
    logic [CNT_W-1:0] len, len_nxt;
    logic [CNT_W-1:0] beat, beat_nxt;
    logic             pop;
    logic             last_beat;
    logic             skid_s_ready;
    logic [DATA_W:0]  skid_m_data;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    logic [TMR_W-1:0] idle_tmr, tmr_nxt;
`endif

    assign last_beat = (beat == len - 1'b1);
    assign pop       = (state == BURST) && !fifo_empty && skid_s_ready;
    assign fifo_ren  = pop;

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        beat_nxt  = beat;
`ifdef FIFO_RD_TIMEOUT_EN
        tmr_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (fifo_rdcnt >= FULL_LEN) begin
                    state_nxt = BURST;
                    len_nxt   = FULL_LEN;
                    beat_nxt  = '0;
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (fifo_empty) begin
                    tmr_nxt = '0;
                end else if (idle_tmr == TMR_LAST) begin
                    // rdcnt may lag a non-empty FIFO; a zero count still flushes one word.
                    state_nxt = BURST;
                    len_nxt   = (fifo_rdcnt == '0) ? CNT_W'(1) : fifo_rdcnt;
                    beat_nxt  = '0;
                end else begin
                    tmr_nxt = idle_tmr + 1'b1;
                end
`endif
            end
            BURST: begin
                if (pop) begin
                    beat_nxt = beat + 1'b1;
                    if (last_beat)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            beat  <= '0;
`ifdef FIFO_RD_TIMEOUT_EN
            idle_tmr <= '0;
`endif
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            beat  <= beat_nxt;
`ifdef FIFO_RD_TIMEOUT_EN
            idle_tmr <= tmr_nxt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            err_flag  <= 1'b0;
        end else begin
            if (m_valid && m_ready && m_last)
                burst_cnt <= burst_cnt + 1'b1;
            if (fifo_err)
                err_flag <= 1'b1;
        end
    end

    rd_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (pop),
        .s_ready (skid_s_ready),
        .s_data  ({fifo_rdata, last_beat}),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (skid_m_data)
    );

    assign m_data = skid_m_data[DATA_W:1];
    assign m_last = skid_m_data[0];

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FWFT FIFO model.
module tb_fifo_burst_reader;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 5;
    localparam int BURST_LEN   = 8;
    localparam int TIMEOUT_CYC = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_rdcnt;
    logic              fifo_err = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [31:0]       burst_cnt;
    logic              err_flag;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .BURST_LEN   (BURST_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_ren   (fifo_ren),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rdcnt (fifo_rdcnt),
        .fifo_err   (fifo_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .burst_cnt  (burst_cnt),
        .err_flag   (err_flag)
    );

    // FIFO model: outputs refresh at each clock edge; force_* emulate a lagging count.
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W:0]   rx[$];
    logic              emp_r = 1'b1;
    logic [DATA_W-1:0] rdata_r = '0;
    logic [CNT_W-1:0]  cnt_r = '0;
    logic              force_empty = 1'b0;
    logic              force_cnt_en = 1'b0;
    logic [CNT_W-1:0]  force_cnt = '0;
    int                underflow = 0;
    int                stab_err = 0;
    logic              stall_q = 1'b0;
    logic [DATA_W:0]   stall_v = '0;
    int                pass_cnt = 0;
    int                chk_cnt = 0;

    assign fifo_empty = emp_r | force_empty;
    assign fifo_rdata = rdata_r;
    assign fifo_rdcnt = force_cnt_en ? force_cnt : cnt_r;

    always @(posedge clk) begin
        if (fifo_ren) begin
            if (fifo_empty || fq.size() == 0) underflow++;
            else void'(fq.pop_front());
        end
        emp_r   <= (fq.size() == 0);
        rdata_r <= (fq.size() != 0) ? fq[0] : '0;
        cnt_r   <= (fq.size() > 31) ? CNT_W'(31) : CNT_W'(fq.size());
        if (m_valid && m_ready) rx.push_back({m_data, m_last});
        if (!rst && stall_q && !(m_valid && ({m_data, m_last} === stall_v))) stab_err++;
        stall_q <= !rst && m_valid && !m_ready;
        stall_v <= {m_data, m_last};
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fq.delete();
        rx.delete();
        force_empty = 1'b0;
        force_cnt_en = 1'b0;
        fifo_err = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int n, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + DATA_W'(i));
    endtask

    task automatic wait_rx(input int n, input int bound, output int cyc);
        cyc = 0;
        while (rx.size() < n && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Counts beats that differ from base+i with m_last every BURST_LEN beats.
    function automatic int seq_errs(input int n, input logic [DATA_W-1:0] base);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= rx.size() || rx[i] !== {base + DATA_W'(i), (i % BURST_LEN) == BURST_LEN - 1}) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%0b exp=0", m_valid); else pass_cnt++;
        chk_cnt++; if (fifo_ren !== 1'b0) $display("FAIL reset_fifo_ren got=%0b exp=0", fifo_ren); else pass_cnt++;
        chk_cnt++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%0b exp=0", m_last); else pass_cnt++;
        chk_cnt++; if (m_data !== '0) $display("FAIL reset_m_data got=%0h exp=0", m_data); else pass_cnt++;
        chk_cnt++; if (burst_cnt !== 32'd0) $display("FAIL reset_burst_cnt got=%0d exp=0", burst_cnt); else pass_cnt++;
        chk_cnt++; if (err_flag !== 1'b0) $display("FAIL reset_err_flag got=%0b exp=0", err_flag); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_two_bursts();
        int cyc, bad;
        do_reset();
        load(16, 0);
        wait_rx(16, 200, cyc);
        chk_cnt++; if (rx.size() != 16) $display("FAIL two_bursts_count got=%0d exp=16", rx.size()); else pass_cnt++;
        chk_cnt++; if (cyc > 21) $display("FAIL two_bursts_throughput got=%0d cycles exp<=21", cyc); else pass_cnt++;
        bad = seq_errs(16, 0);
        chk_cnt++; if (bad != 0) $display("FAIL two_bursts_data got=%0d bad beats exp=0", bad); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (burst_cnt !== 32'd2) $display("FAIL two_bursts_burst_cnt got=%0d exp=2", burst_cnt); else pass_cnt++;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL two_bursts_drained got=%0b exp=0", m_valid); else pass_cnt++;
    endtask

    task automatic test_partial();
        do_reset();
        load(5, 32'h50);
`ifdef FIFO_RD_TIMEOUT_EN
        begin
            int cyc, bad;
            wait_rx(5, 300, cyc);
            bad = 0;
            for (int i = 0; i < 5; i++)
                if (i >= rx.size() || rx[i] !== {32'h50 + DATA_W'(i), i == 4}) bad++;
            chk_cnt++; if (bad != 0) $display("FAIL partial_data got=%0d bad beats exp=0", bad); else pass_cnt++;
            repeat (3) @(negedge clk);
            chk_cnt++; if (burst_cnt !== 32'd1) $display("FAIL partial_burst_cnt got=%0d exp=1", burst_cnt); else pass_cnt++;
            chk_cnt++; if (rx.size() != 5) $display("FAIL partial_count got=%0d exp=5", rx.size()); else pass_cnt++;
        end
`else
        begin
            int seen = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (m_valid) seen++;
            end
            chk_cnt++; if (seen != 0) $display("FAIL partial_no_drain got=%0d valid cycles exp=0", seen); else pass_cnt++;
            chk_cnt++; if (fq.size() != 5) $display("FAIL partial_fifo_level got=%0d exp=5", fq.size()); else pass_cnt++;
            chk_cnt++; if (burst_cnt !== 32'd0) $display("FAIL partial_burst_cnt got=%0d exp=0", burst_cnt); else pass_cnt++;
        end
`endif
    endtask

    task automatic test_random();
        int cyc = 0, bad;
        do_reset();
        load(32, 32'h1000);
        while (rx.size() < 32 && cyc < 3000) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (rx.size() != 32) $display("FAIL random_count got=%0d exp=32", rx.size()); else pass_cnt++;
        bad = seq_errs(32, 32'h1000);
        chk_cnt++; if (bad != 0) $display("FAIL random_data got=%0d bad beats exp=0", bad); else pass_cnt++;
        chk_cnt++; if (burst_cnt !== 32'd4) $display("FAIL random_burst_cnt got=%0d exp=4", burst_cnt); else pass_cnt++;
        chk_cnt++; if (stab_err != 0) $display("FAIL random_stall_stable got=%0d exp=0", stab_err); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int cyc, bad;
        logic [DATA_W-1:0] head;
        do_reset();
        load(16, 32'h200);
        wait_rx(3, 100, cyc);
        rst = 1'b1;
        #1;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid got=%0b exp=0", m_valid); else pass_cnt++;
        chk_cnt++; if (burst_cnt !== 32'd0) $display("FAIL midrst_burst_cnt got=%0d exp=0", burst_cnt); else pass_cnt++;
        head = fq[0];
        rx.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_rx(8, 100, cyc);
        bad = seq_errs(8, head);
        chk_cnt++; if (bad != 0) $display("FAIL midrst_restart got=%0d bad beats (head %0h) exp=0", bad, head); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (burst_cnt !== 32'd1) $display("FAIL midrst_burst_cnt_after got=%0d exp=1", burst_cnt); else pass_cnt++;
    endtask

    task automatic test_err();
        int cyc, bad;
        do_reset();
        load(16, 32'h300);
        @(negedge clk);
        fifo_err = 1'b1;
        @(negedge clk);
        fifo_err = 1'b0;
        chk_cnt++; if (err_flag !== 1'b1) $display("FAIL err_set got=%0b exp=1", err_flag); else pass_cnt++;
        wait_rx(16, 200, cyc);
        bad = seq_errs(16, 32'h300);
        chk_cnt++; if (bad != 0) $display("FAIL err_data got=%0d bad beats exp=0", bad); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (burst_cnt !== 32'd2) $display("FAIL err_burst_cnt got=%0d exp=2", burst_cnt); else pass_cnt++;
        chk_cnt++; if (err_flag !== 1'b1) $display("FAIL err_sticky got=%0b exp=1", err_flag); else pass_cnt++;
        do_reset();
        chk_cnt++; if (err_flag !== 1'b0) $display("FAIL err_clear got=%0b exp=0", err_flag); else pass_cnt++;
    endtask

    task automatic test_lag();
        int cyc = 0, bad;
        do_reset();
        force_cnt_en = 1'b1;
        force_cnt = CNT_W'(7);
        load(8, 32'h400);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            force_empty = ~force_empty;
        end
        chk_cnt++; if (fq.size() != 8) $display("FAIL lag_no_pop got=%0d words left exp=8", fq.size()); else pass_cnt++;
        force_cnt = CNT_W'(8);
        while (rx.size() < 8 && cyc < 200) begin
            @(negedge clk);
            force_empty = ~force_empty;
            cyc++;
        end
        force_empty = 1'b0;
        repeat (20) @(negedge clk);
        chk_cnt++; if (rx.size() != 8) $display("FAIL lag_beats got=%0d exp=8", rx.size()); else pass_cnt++;
        bad = seq_errs(8, 32'h400);
        chk_cnt++; if (bad != 0) $display("FAIL lag_data got=%0d bad beats exp=0", bad); else pass_cnt++;
        chk_cnt++; if (burst_cnt !== 32'd1) $display("FAIL lag_burst_cnt got=%0d exp=1", burst_cnt); else pass_cnt++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_partial();
        test_random();
        test_mid_reset();
        test_err();
        test_lag();
        chk_cnt++; if (underflow != 0) $display("FAIL no_underflow got=%0d exp=0", underflow); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
